// File: rtl/p405s_icu_dp_fillbuf.sv
// rtl/p405s_icu_dp_fillbuf.sv - ICU line-fill buffer with critical-word-first fill and fetch bypass
module p405s_icu_dp_fillbuf #(
    parameter int WORDS = 8,
    parameter int IDX_W = 3
) (
    input  logic             CB,
    input  logic             rstN,
    input  logic             fill_start,
    input  logic [IDX_W-1:0] fill_crit,
    input  logic             beat_val,
    input  logic [0:31]      beat_data,
    input  logic             beat_err,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [0:31]      inst_data,
    output logic             inst_ld,
    output logic             fill_busy,
    output logic             line_valid,
    output logic             fill_done,
    output logic             fill_err
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state;
    logic [IDX_W-1:0] crit;
    logic [IDX_W-1:0] cnt;
    logic [0:31]      mem [WORDS];
    logic [WORDS-1:0] vld;

    logic             start_acc;
    logic             good_beat;
    logic             err_beat;
    logic [IDX_W-1:0] wr_idx;
    logic             last_beat;
    logic             bypass;
    logic             rd_acc;

    assign start_acc = (state == IDLE) && fill_start;
    assign good_beat = (state == FILL) && beat_val && !beat_err;
    assign err_beat  = (state == FILL) && beat_val && beat_err;
    assign wr_idx    = crit + cnt;
    assign last_beat = (cnt == IDX_W'(WORDS - 1));
    assign bypass    = good_beat && (wr_idx == rd_idx);
    // An aborting beat or a new fill invalidates the line this cycle, so no read may slip through.
    assign rd_acc    = rd_req && (vld[rd_idx] || bypass) && !err_beat && !start_acc;
    assign fill_busy = (state == FILL);

    // Word storage needs no reset: the valid bits gate every read.
    always_ff @(posedge CB) begin
        if (rstN && good_beat) begin
            mem[wr_idx] <= beat_data;
        end
    end

    always_ff @(posedge CB) begin
        if (!rstN) begin
            state      <= IDLE;
            crit       <= '0;
            cnt        <= '0;
            vld        <= '0;
            inst_data  <= '0;
            inst_ld    <= 1'b0;
            line_valid <= 1'b0;
            fill_done  <= 1'b0;
            fill_err   <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            inst_ld   <= rd_acc;
            if (rd_acc) begin
                inst_data <= bypass ? beat_data : mem[rd_idx];
            end
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        crit       <= fill_crit;
                        cnt        <= '0;
                        vld        <= '0;
                        line_valid <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (err_beat) begin
                        vld      <= '0;
                        fill_err <= 1'b1;
                        state    <= IDLE;
                    end else if (good_beat) begin
                        vld[wr_idx] <= 1'b1;
                        cnt         <= cnt + IDX_W'(1);
                        if (last_beat) begin
                            fill_done  <= 1'b1;
                            line_valid <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_icu_dp_fillbuf.sv
// tb/tb_p405s_icu_dp_fillbuf.sv - self-checking bench for the ICU line-fill buffer
module tb_p405s_icu_dp_fillbuf;

    logic        CB = 1'b0;
    logic        rstN;
    logic        fill_start;
    logic [2:0]  fill_crit;
    logic        beat_val;
    logic [0:31] beat_data;
    logic        beat_err;
    logic        rd_req;
    logic [2:0]  rd_idx;
    logic [0:31] inst_data;
    logic        inst_ld;
    logic        fill_busy;
    logic        line_valid;
    logic        fill_done;
    logic        fill_err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    p405s_icu_dp_fillbuf #(.WORDS(8), .IDX_W(3)) dut (
        .CB(CB), .rstN(rstN), .fill_start(fill_start), .fill_crit(fill_crit),
        .beat_val(beat_val), .beat_data(beat_data), .beat_err(beat_err),
        .rd_req(rd_req), .rd_idx(rd_idx), .inst_data(inst_data), .inst_ld(inst_ld),
        .fill_busy(fill_busy), .line_valid(line_valid), .fill_done(fill_done), .fill_err(fill_err)
    );

    always #5 CB = ~CB;

    // Advance one clock; any acknowledged read is matched against the scoreboard.
    task automatic tick();
        logic [31:0] exp;
        @(posedge CB);
        #1;
        if (inst_ld === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_ld: inst_ld=1 data=%h, no read expected", inst_data);
            end else begin
                exp = exp_q.pop_front();
                if (inst_data !== exp) begin
                    bad++;
                    $display("FAIL rd_data: got %h expected %h", inst_data, exp);
                end
            end
        end
    endtask

    task automatic start_fill(input logic [2:0] c);
        fill_start = 1'b1;
        fill_crit  = c;
        tick();
        fill_start = 1'b0;
        total++;
        if (fill_busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_busy_after_start: got %b expected 1", fill_busy);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic e);
        beat_val  = 1'b1;
        beat_data = d;
        beat_err  = e;
        tick();
        beat_val  = 1'b0;
        beat_err  = 1'b0;
    endtask

    task automatic check_q_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d acks missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        rd_req = 1'b1;
        rd_idx = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({inst_data, inst_ld, fill_busy, line_valid, fill_done, fill_err} !== 37'd0) begin
                bad++;
                $display("FAIL reset_outputs: data=%h ld=%b busy=%b lv=%b done=%b err=%b expected all 0",
                         inst_data, inst_ld, fill_busy, line_valid, fill_done, fill_err);
            end
        end
        rd_req = 1'b0;
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        int dn = 0;
        start_fill(3'd6);
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hA0 + i, 1'b0);
            dn += fill_done;
        end
        total++;
        if (line_valid !== 1'b1 || fill_busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_line_valid: lv=%b busy=%b expected lv=1 busy=0", line_valid, fill_busy);
        end
        tick();
        dn += fill_done;
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL wrap_done_pulses: got %0d expected 1", dn);
        end
        // Back-to-back reads of every word: word w holds A0 + ((w - 6) mod 8).
        for (int w = 0; w < 8; w++) begin
            rd_req = 1'b1;
            rd_idx = 3'(w);
            exp_q.push_back(32'hA0 + ((w + 2) % 8));
            tick();
            total++;
            if (inst_ld !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back_ld: idx=%0d got %b expected 1", w, inst_ld);
            end
        end
        rd_req = 1'b0;
        tick();
        check_q_empty("wrap_reads");
    endtask

    task automatic test_bypass();
        start_fill(3'd6);
        rd_req = 1'b1;
        rd_idx = 3'd6;
        exp_q.push_back(32'h1234_5678);
        send_beat(32'h1234_5678, 1'b0);
        rd_req = 1'b0;
        total++;
        if (inst_ld !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ld: got %b expected 1", inst_ld);
        end
        for (int i = 1; i < 8; i++) send_beat(32'h5000 + i, 1'b0);
        total++;
        if (line_valid !== 1'b1) begin
            bad++;
            $display("FAIL bypass_fill_complete: lv=%b expected 1", line_valid);
        end
        check_q_empty("bypass");
    endtask

    task automatic test_stall();
        start_fill(3'd6);
        send_beat(32'hB0, 1'b0);
        send_beat(32'hB1, 1'b0);
        rd_req = 1'b1;
        rd_idx = 3'd2;
        tick();
        total++;
        if (inst_ld !== 1'b0) begin
            bad++;
            $display("FAIL stall_no_ld: got %b expected 0", inst_ld);
        end
        send_beat(32'hB2, 1'b0);
        send_beat(32'hB3, 1'b0);
        total++;
        if (inst_ld !== 1'b0 || inst_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL stall_hold: ld=%b data=%h expected ld=0 data=12345678", inst_ld, inst_data);
        end
        exp_q.push_back(32'hB4);
        send_beat(32'hB4, 1'b0);
        rd_req = 1'b0;
        total++;
        if (inst_ld !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ld: got %b expected 1", inst_ld);
        end
        for (int i = 5; i < 8; i++) send_beat(32'hB0 + i, 1'b0);
        check_q_empty("stall");
    endtask

    task automatic test_error();
        int ec = 0;
        start_fill(3'd6);
        for (int i = 0; i < 4; i++) send_beat(32'hE0 + i, 1'b0);
        rd_req = 1'b1;
        rd_idx = 3'd6;
        send_beat(32'hE4, 1'b1);
        ec += fill_err;
        total++;
        if (inst_ld !== 1'b0 || fill_err !== 1'b1 || fill_busy !== 1'b0) begin
            bad++;
            $display("FAIL err_abort: ld=%b err=%b busy=%b expected 0,1,0", inst_ld, fill_err, fill_busy);
        end
        for (int i = 5; i < 8; i++) begin
            send_beat(32'hE0 + i, 1'b0);
            ec += fill_err;
            total++;
            if (inst_ld !== 1'b0 || line_valid !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b0) begin
                bad++;
                $display("FAIL err_ignored_beats: ld=%b lv=%b done=%b busy=%b expected all 0",
                         inst_ld, line_valid, fill_done, fill_busy);
            end
        end
        rd_req = 1'b0;
        total++;
        if (ec != 1) begin
            bad++;
            $display("FAIL err_pulses: got %0d expected 1", ec);
        end
        check_q_empty("error");
    endtask

    task automatic test_reset_mid_fill();
        int dn = 0;
        start_fill(3'd0);
        for (int i = 0; i < 3; i++) send_beat(32'hC0 + i, 1'b0);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        total++;
        if (fill_busy !== 1'b0 || line_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: busy=%b lv=%b expected 0,0", fill_busy, line_valid);
        end
        rd_req = 1'b1;
        rd_idx = 3'd0;
        for (int i = 3; i < 6; i++) send_beat(32'hC0 + i, 1'b0);
        rd_req = 1'b0;
        total++;
        if (fill_busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_beats_ignored: busy=%b expected 0", fill_busy);
        end
        start_fill(3'd0);
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hD0 + i, 1'b0);
            dn += fill_done;
            if (i == 6) begin
                total++;
                if (dn != 0) begin
                    bad++;
                    $display("FAIL midreset_early_done: got %0d expected 0", dn);
                end
            end
        end
        total++;
        if (dn != 1 || line_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset_done: pulses=%0d lv=%b expected 1,1", dn, line_valid);
        end
        for (int w = 0; w < 3; w++) begin
            rd_req = 1'b1;
            rd_idx = 3'(w);
            exp_q.push_back(32'hD0 + w);
            tick();
        end
        rd_req = 1'b0;
        tick();
        check_q_empty("midreset_reads");
    endtask

    task automatic test_start_blocks_read();
        rd_req = 1'b1;
        rd_idx = 3'd1;
        start_fill(3'd3);
        rd_req = 1'b0;
        total++;
        if (inst_ld !== 1'b0 || line_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_blocks_read: ld=%b lv=%b expected 0,0", inst_ld, line_valid);
        end
        for (int i = 0; i < 8; i++) send_beat(32'hF0 + i, 1'b0);
        rd_req = 1'b1;
        rd_idx = 3'd1;
        exp_q.push_back(32'hF6);
        tick();
        rd_req = 1'b0;
        tick();
        check_q_empty("start_blocks_read");
    endtask

    initial begin
        rstN = 1'b0;
        fill_start = 1'b0;
        fill_crit = 3'd0;
        beat_val = 1'b0;
        beat_data = '0;
        beat_err = 1'b0;
        rd_req = 1'b0;
        rd_idx = 3'd0;
        test_reset();
        test_wrap();
        test_bypass();
        test_stall();
        test_error();
        test_reset_mid_fill();
        test_start_blocks_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
